instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the fetch-stage decoder: turns a decoded op_t plus operand fields into a 32-bit MIPS
//  instruction word. The decode table is the golden mapping: decoding out_instr yields in_op again.
//  Single-register valid/ready pipeline stage. Used by the self-check trace generator and the
//  exception-injection path. Counts ops that have no encoding.
// PARAMETERS
//  CNT_W   16   width of the illegal-op counter (saturating)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      request valid
//  in_ready     out  1      stage can accept this cycle
//  in_op        in   op_t   operation to encode
//  in_rs        in   5      rs / base field
//  in_rt        in   5      rt field
//  in_rd        in   5      rd field
//  in_shamt     in   5      shift amount, used by SLL/SRL/SRA only
//  in_imm       in   16     immediate / branch offset / load-store offset
//  in_target    in   26     J/JAL target field
//  out_valid    out  1      encoded word valid
//  out_ready    in   1      consumer accepts
//  out_instr    out  32     encoded instruction word
//  out_illegal  out  1      in_op had no encoding; out_instr is 0
//  illegal_cnt  out  CNT_W  number of illegal ops accepted since reset
// BEHAVIOUR
//  - Reset: out_valid=0, out_instr=0, out_illegal=0, illegal_cnt=0. Any in-flight word is dropped.
//  - in_ready = !out_valid || out_ready. Accept = in_valid && in_ready. Latency is 1 cycle.
//  - On accept, the output register loads the encoded word, out_illegal, and sets out_valid=1.
//  - Output drain: if out_valid && out_ready and there is no accept, out_valid clears next cycle.
//    Drain and accept in the same cycle give back-to-back words with full throughput.
//  - While out_valid && !out_ready: out_instr and out_illegal hold stable and in_ready=0.
//  - R-type: opcode 000000, {rs,rt,rd,shamt,funct}. Field use per op:
//    - SLL/SRL/SRA: rs=0.
//    - SLLV/SRLV/SRAV, ALU, SLT/SLTU: shamt=0.
//    - JR: rs only. JALR: rs and rd.
//    - MFHI/MFLO: rd only. MTHI/MTLO: rs only.
//    - MULT/MULTU/DIV/DIVU: rs and rt.
//    - SYSCALL/BREAK: code field = 0.
//    - Fields an op does not use are forced to 0, regardless of the input value.
//  - NOP encodes as 32'h0000_0000. SLL with rd=0 is emitted as given; it decodes as NOP, and that aliasing is allowed.
//  - REGIMM: opcode 000001, rs, rt = BLTZ 00000 / BGEZ 00001 / BLTZAL 10000 / BGEZAL 10001, imm.
//  - J/JAL: {opcode, in_target}.
//  - I-type ops (BEQ..LUI, loads, stores): {opcode, rs, rt, imm}.
//    - BLEZ/BGTZ force rt=0.
//    - LUI forces rs=0.
//  - COP0:
//    - MFC0 = {010000,00000,rt,rd,11'b0}.
//    - MTC0 = {010000,00100,rt,rd,11'b0}.
//    - ERET = 32'h4200_0018.
//  - Illegal ops: DECODE_ERROR, MUL and any op_t value not listed above.
//    - out_instr=0 and out_illegal=1.
//    - illegal_cnt increments on accept and saturates at all-ones.
//  - Purely combinational encode feeding one register. No other state.
// TESTING
//  - ADDU rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_valid=1, out_instr=0x0022_1821, out_illegal=0.
//  - ADDIU rs=0 rt=8 imm=0x1234 -> 0x2408_1234. BGEZAL rs=4 imm=0xFFFF -> 0x0491_FFFF.
//  - ERET with junk rs/rt/imm -> 0x4200_0018. BLEZ rs=3 rt=7 imm=4 -> 0x1860_0004 (rt forced 0).
//  - Backpressure: accept ADDU, hold out_ready=0 for 3 cycles -> in_ready=0 and out_instr stable.
//    Raise out_ready together with in_valid -> two words on consecutive cycles.
//  - DECODE_ERROR x3 -> out_instr=0, out_illegal=1, illegal_cnt=3.
//    With CNT_W=2, five illegal ops -> illegal_cnt holds at 3.
//  - Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, illegal_cnt=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: decoded op_t plus operand fields -> 32-bit instruction word,
// registered behind a single valid/ready stage with a saturating count of unencodable ops.

package instr_encoder_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_JR, OP_JALR, OP_SYSCALL, OP_BREAK,
        OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_J, OP_JAL,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_MFC0, OP_MTC0, OP_ERET,
        OP_MUL, OP_DECODE_ERROR
    } op_t;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02,
                           OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05,
                           OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI  = 6'h08,
                           OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0a, OPC_SLTIU = 6'h0b,
                           OPC_ANDI    = 6'h0c, OPC_ORI    = 6'h0d, OPC_XORI  = 6'h0e,
                           OPC_LUI     = 6'h0f, OPC_COP0   = 6'h10, OPC_LB    = 6'h20,
                           OPC_LH      = 6'h21, OPC_LW     = 6'h23, OPC_LBU   = 6'h24,
                           OPC_LHU     = 6'h25, OPC_SB     = 6'h28, OPC_SH    = 6'h29,
                           OPC_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04,
                           FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09,
                           FN_SYSCALL = 6'h0c, FN_BREAK = 6'h0d,
                           FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO  = 6'h12, FN_MTLO  = 6'h13,
                           FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV   = 6'h1a, FN_DIVU  = 6'h1b,
                           FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB   = 6'h22, FN_SUBU  = 6'h23,
                           FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR   = 6'h26, FN_NOR   = 6'h27,
                           FN_SLT  = 6'h2a, FN_SLTU  = 6'h2b, FN_ERET  = 6'h18;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04;

endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [4:0] Z5 = 5'd0;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        accept;

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        enc_instr   = '0;
        enc_illegal = 1'b0;
        case (in_op)
            OP_NOP:     enc_instr = '0;
            OP_SLL:     enc_instr = r_word(Z5, in_rt, in_rd, in_shamt, FN_SLL);
            OP_SRL:     enc_instr = r_word(Z5, in_rt, in_rd, in_shamt, FN_SRL);
            OP_SRA:     enc_instr = r_word(Z5, in_rt, in_rd, in_shamt, FN_SRA);
            OP_SLLV:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SLLV);
            OP_SRLV:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SRLV);
            OP_SRAV:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SRAV);
            OP_JR:      enc_instr = r_word(in_rs, Z5, Z5, Z5, FN_JR);
            OP_JALR:    enc_instr = r_word(in_rs, Z5, in_rd, Z5, FN_JALR);
            OP_SYSCALL: enc_instr = r_word(Z5, Z5, Z5, Z5, FN_SYSCALL);
            OP_BREAK:   enc_instr = r_word(Z5, Z5, Z5, Z5, FN_BREAK);
            OP_MFHI:    enc_instr = r_word(Z5, Z5, in_rd, Z5, FN_MFHI);
            OP_MFLO:    enc_instr = r_word(Z5, Z5, in_rd, Z5, FN_MFLO);
            OP_MTHI:    enc_instr = r_word(in_rs, Z5, Z5, Z5, FN_MTHI);
            OP_MTLO:    enc_instr = r_word(in_rs, Z5, Z5, Z5, FN_MTLO);
            OP_MULT:    enc_instr = r_word(in_rs, in_rt, Z5, Z5, FN_MULT);
            OP_MULTU:   enc_instr = r_word(in_rs, in_rt, Z5, Z5, FN_MULTU);
            OP_DIV:     enc_instr = r_word(in_rs, in_rt, Z5, Z5, FN_DIV);
            OP_DIVU:    enc_instr = r_word(in_rs, in_rt, Z5, Z5, FN_DIVU);
            OP_ADD:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_ADD);
            OP_ADDU:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_ADDU);
            OP_SUB:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SUB);
            OP_SUBU:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SUBU);
            OP_AND:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_AND);
            OP_OR:      enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_OR);
            OP_XOR:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_XOR);
            OP_NOR:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_NOR);
            OP_SLT:     enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SLT);
            OP_SLTU:    enc_instr = r_word(in_rs, in_rt, in_rd, Z5, FN_SLTU);
            // REGIMM variants are selected by the rt field, so rt is never taken from the input
            OP_BLTZ:    enc_instr = i_word(OPC_REGIMM, in_rs, RT_BLTZ, in_imm);
            OP_BGEZ:    enc_instr = i_word(OPC_REGIMM, in_rs, RT_BGEZ, in_imm);
            OP_BLTZAL:  enc_instr = i_word(OPC_REGIMM, in_rs, RT_BLTZAL, in_imm);
            OP_BGEZAL:  enc_instr = i_word(OPC_REGIMM, in_rs, RT_BGEZAL, in_imm);
            OP_J:       enc_instr = {OPC_J, in_target};
            OP_JAL:     enc_instr = {OPC_JAL, in_target};
            OP_BEQ:     enc_instr = i_word(OPC_BEQ, in_rs, in_rt, in_imm);
            OP_BNE:     enc_instr = i_word(OPC_BNE, in_rs, in_rt, in_imm);
            OP_BLEZ:    enc_instr = i_word(OPC_BLEZ, in_rs, Z5, in_imm);
            OP_BGTZ:    enc_instr = i_word(OPC_BGTZ, in_rs, Z5, in_imm);
            OP_ADDI:    enc_instr = i_word(OPC_ADDI, in_rs, in_rt, in_imm);
            OP_ADDIU:   enc_instr = i_word(OPC_ADDIU, in_rs, in_rt, in_imm);
            OP_SLTI:    enc_instr = i_word(OPC_SLTI, in_rs, in_rt, in_imm);
            OP_SLTIU:   enc_instr = i_word(OPC_SLTIU, in_rs, in_rt, in_imm);
            OP_ANDI:    enc_instr = i_word(OPC_ANDI, in_rs, in_rt, in_imm);
            OP_ORI:     enc_instr = i_word(OPC_ORI, in_rs, in_rt, in_imm);
            OP_XORI:    enc_instr = i_word(OPC_XORI, in_rs, in_rt, in_imm);
            OP_LUI:     enc_instr = i_word(OPC_LUI, Z5, in_rt, in_imm);
            OP_LB:      enc_instr = i_word(OPC_LB, in_rs, in_rt, in_imm);
            OP_LH:      enc_instr = i_word(OPC_LH, in_rs, in_rt, in_imm);
            OP_LW:      enc_instr = i_word(OPC_LW, in_rs, in_rt, in_imm);
            OP_LBU:     enc_instr = i_word(OPC_LBU, in_rs, in_rt, in_imm);
            OP_LHU:     enc_instr = i_word(OPC_LHU, in_rs, in_rt, in_imm);
            OP_SB:      enc_instr = i_word(OPC_SB, in_rs, in_rt, in_imm);
            OP_SH:      enc_instr = i_word(OPC_SH, in_rs, in_rt, in_imm);
            OP_SW:      enc_instr = i_word(OPC_SW, in_rs, in_rt, in_imm);
            OP_MFC0:    enc_instr = {OPC_COP0, RS_MF, in_rt, in_rd, 11'b0};
            OP_MTC0:    enc_instr = {OPC_COP0, RS_MT, in_rt, in_rd, 11'b0};
            OP_ERET:    enc_instr = 32'h4200_0018;
            default:    enc_illegal = 1'b1;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_instr   <= enc_instr;
            out_illegal <= enc_illegal;
            if (enc_illegal && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, randomized traffic against a
// field-rule reference model with a queue scoreboard, and handshake/counter/reset corner cases.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    op_t         in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [31:0] out_instr;
    logic [15:0] illegal_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [1:0]  b_illegal_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    instr_encoder #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(OP_DECODE_ERROR),
        .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0), .in_shamt(5'd0), .in_imm(16'd0),
        .in_target(26'd0), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_instr(b_out_instr), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: each op is described by opcode/funct and which fields it keeps; the word is then
    // assembled arithmetically. Returns {illegal, word}.
    function automatic logic [32:0] ref_encode(input op_t op, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [15:0] imm, input logic [25:0] tgt);
        int opc = 0, fn = 0, rs_fix = -1, rt_fix = -1;
        bit k_rs = 0, k_rt = 0, k_rd = 0, k_sh = 0, k_imm = 0, k_tgt = 0, legal = 1;
        longint w;
        case (op)
            OP_NOP: ;
            OP_SLL, OP_SRL, OP_SRA: begin
                k_rt = 1; k_rd = 1; k_sh = 1;
                fn = (op == OP_SLL) ? 0 : (op == OP_SRL) ? 2 : 3;
            end
            OP_SLLV, OP_SRLV, OP_SRAV: begin
                k_rs = 1; k_rt = 1; k_rd = 1;
                fn = (op == OP_SLLV) ? 4 : (op == OP_SRLV) ? 6 : 7;
            end
            OP_JR:      begin k_rs = 1; fn = 8; end
            OP_JALR:    begin k_rs = 1; k_rd = 1; fn = 9; end
            OP_SYSCALL: fn = 12;
            OP_BREAK:   fn = 13;
            OP_MFHI:    begin k_rd = 1; fn = 16; end
            OP_MTHI:    begin k_rs = 1; fn = 17; end
            OP_MFLO:    begin k_rd = 1; fn = 18; end
            OP_MTLO:    begin k_rs = 1; fn = 19; end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                k_rs = 1; k_rt = 1; fn = 24 + (int'(op) - int'(OP_MULT));
            end
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR: begin
                k_rs = 1; k_rt = 1; k_rd = 1; fn = 32 + (int'(op) - int'(OP_ADD));
            end
            OP_SLT, OP_SLTU: begin
                k_rs = 1; k_rt = 1; k_rd = 1; fn = (op == OP_SLT) ? 42 : 43;
            end
            OP_BLTZ:   begin opc = 1; k_rs = 1; k_imm = 1; rt_fix = 0;  end
            OP_BGEZ:   begin opc = 1; k_rs = 1; k_imm = 1; rt_fix = 1;  end
            OP_BLTZAL: begin opc = 1; k_rs = 1; k_imm = 1; rt_fix = 16; end
            OP_BGEZAL: begin opc = 1; k_rs = 1; k_imm = 1; rt_fix = 17; end
            OP_J:      begin opc = 2; k_tgt = 1; end
            OP_JAL:    begin opc = 3; k_tgt = 1; end
            OP_BEQ, OP_BNE: begin opc = (op == OP_BEQ) ? 4 : 5; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_BLEZ, OP_BGTZ: begin opc = (op == OP_BLEZ) ? 6 : 7; k_rs = 1; k_imm = 1; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                opc = 8 + (int'(op) - int'(OP_ADDI)); k_rs = 1; k_rt = 1; k_imm = 1;
            end
            OP_LUI: begin opc = 15; k_rt = 1; k_imm = 1; end
            OP_LB:  begin opc = 32; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_LH:  begin opc = 33; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_LW:  begin opc = 35; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_LBU: begin opc = 36; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_LHU: begin opc = 37; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_SB:  begin opc = 40; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_SH:  begin opc = 41; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_SW:  begin opc = 43; k_rs = 1; k_rt = 1; k_imm = 1; end
            OP_MFC0: begin opc = 16; rs_fix = 0; k_rt = 1; k_rd = 1; end
            OP_MTC0: begin opc = 16; rs_fix = 4; k_rt = 1; k_rd = 1; end
            OP_ERET: begin opc = 16; rs_fix = 16; fn = 24; end
            default: legal = 0;
        endcase
        if (!legal) return {1'b1, 32'h0};
        w = longint'(opc) * (64'd1 << 26) + longint'(fn);
        if (rs_fix >= 0) w += longint'(rs_fix) * (64'd1 << 21);
        else if (k_rs)   w += longint'(rs) * (64'd1 << 21);
        if (rt_fix >= 0) w += longint'(rt_fix) * (64'd1 << 16);
        else if (k_rt)   w += longint'(rt) * (64'd1 << 16);
        if (k_rd)  w += longint'(rd) * (64'd1 << 11);
        if (k_sh)  w += longint'(sh) * 64;
        if (k_imm) w += longint'(imm);
        if (k_tgt) w += longint'(tgt);
        return {1'b0, w[31:0]};
    endfunction

    task automatic drive(input op_t op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        op_t         op;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_instr;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[14];
    logic [32:0] q[$];
    logic [32:0] r;
    logic [31:0] held;
    int exp_cnt;
    bit acc;

    initial begin
        vecs[0]  = '{OP_ADDU,    5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h0022_1821, 1'b0};
        vecs[1]  = '{OP_ADDIU,   5'd0,  5'd8,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h2408_1234, 1'b0};
        vecs[2]  = '{OP_BGEZAL,  5'd4,  5'h1f, 5'd9,  5'd2,  16'hffff, 26'h0,       32'h0491_ffff, 1'b0};
        vecs[3]  = '{OP_ERET,    5'h1a, 5'h0c, 5'd7,  5'd3,  16'h5555, 26'h155,     32'h4200_0018, 1'b0};
        vecs[4]  = '{OP_BLEZ,    5'd3,  5'd7,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h1860_0004, 1'b0};
        vecs[5]  = '{OP_JR,      5'd31, 5'd5,  5'd6,  5'd7,  16'h0,    26'h0,       32'h03e0_0008, 1'b0};
        vecs[6]  = '{OP_SLL,     5'd9,  5'd2,  5'd4,  5'd3,  16'h0,    26'h0,       32'h0002_20c0, 1'b0};
        vecs[7]  = '{OP_J,       5'd7,  5'd7,  5'd7,  5'd7,  16'h7777, 26'h3ffffff, 32'h0bff_ffff, 1'b0};
        vecs[8]  = '{OP_LUI,     5'd5,  5'd6,  5'd0,  5'd0,  16'habcd, 26'h0,       32'h3c06_abcd, 1'b0};
        vecs[9]  = '{OP_MTC0,    5'd9,  5'd3,  5'd12, 5'd1,  16'h0,    26'h0,       32'h4083_6000, 1'b0};
        vecs[10] = '{OP_SW,      5'd29, 5'd31, 5'd0,  5'd0,  16'hfffc, 26'h0,       32'hafbf_fffc, 1'b0};
        vecs[11] = '{OP_MUL,     5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       32'h0000_0000, 1'b1};
        vecs[12] = '{OP_NOP,     5'd1,  5'd2,  5'd3,  5'd4,  16'h1111, 26'h0,       32'h0000_0000, 1'b0};
        vecs[13] = '{OP_SYSCALL, 5'd1,  5'd2,  5'd3,  5'd4,  16'h1111, 26'h0,       32'h0000_000c, 1'b0};

        out_ready = 1'b1;
        drive(OP_NOP, 0, 0, 0, 0, 0, 0);
        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset out_illegal", 32'(out_illegal), 32'd0);
        check("reset illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one word at a time with the consumer always ready.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d %s out_instr", i, vecs[i].op.name()), out_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d out_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_ill));
        end
        @(posedge clk); #1;
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure, scoreboarded against the reference model.
        do_reset();
        q.delete();
        exp_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            drive(op_t'(6'($urandom_range(0, 63))), 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 16'($urandom), 26'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check("rand in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
            acc = in_valid && (q.size() == 0 || out_ready);
            r = ref_encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
            @(posedge clk); #1;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                q.push_back(r);
                if (r[32] && exp_cnt < 16'hffff) exp_cnt++;
            end
            check("rand out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check($sformatf("rand %s out_instr", in_op.name()), out_instr, q[0][31:0]);
                check("rand out_illegal", 32'(out_illegal), 32'(q[0][32]));
            end
            check("rand illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
        end

        // Backpressure: ADDU held for 3 cycles, then drained together with a new accept.
        in_valid = 1'b0; out_ready = 1'b1;
        do_reset();
        drive(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        held = out_instr;
        check("bp first word", held, 32'h0022_1821);
        drive(OP_ORI, 5'd9, 5'd9, 5'd9, 5'd9, 16'h9999, 26'h0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp out_instr stable c%0d", c), out_instr, 32'h0022_1821);
        end
        drive(OP_ADDIU, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
        out_ready = 1'b1;
        #1;
        check("bp in_ready on drain", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp second valid", 32'(out_valid), 32'd1);
        check("bp second word", out_instr, 32'h2408_1234);
        @(posedge clk); #1;
        check("bp drained", 32'(out_valid), 32'd0);

        // Three DECODE_ERROR ops, and five into the 2-bit counter instance.
        do_reset();
        drive(OP_DECODE_ERROR, 5'd3, 5'd4, 5'd5, 5'd6, 16'hbeef, 26'h1);
        in_valid = 1'b1; b_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                in_valid = 1'b0;
                check("derr out_instr", out_instr, 32'd0);
                check("derr out_illegal", 32'(out_illegal), 32'd1);
                check("derr illegal_cnt", 32'(illegal_cnt), 32'd3);
                check("small cnt after 3", 32'(b_illegal_cnt), 32'd3);
            end
        end
        b_in_valid = 1'b0;
        check("small cnt saturated", 32'(b_illegal_cnt), 32'd3);
        check("small out_illegal", 32'(b_out_illegal), 32'd1);
        check("big cnt unchanged", 32'(illegal_cnt), 32'd3);

        // Reset with a stalled word in flight.
        drive(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset-flight out_valid", 32'(out_valid), 32'd0);
        check("reset-flight illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("reset-flight in_ready", 32'(in_ready), 32'd1);
        check("reset-flight out_instr", out_instr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
